// File: rtl/aes_block_uart_tx_pkg.sv
// Shared types for the AES block to UART byte serializer.
// Holds the serializer state encoding and AES block sizes.
package aes_uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_GAP
  } state_t;

  localparam int AES_BLOCK_BITS  = 128;
  localparam int AES_BLOCK_BYTES = 16;

endpackage

// File: rtl/aes_block_uart_tx_if.sv
// Block handshake between the AES core output and the serializer.
// Ports: block_i (data), block_valid_i, block_ready_o.
interface aes_block_uart_tx_if #(
  parameter int NUM_BYTES = 16
);

  logic [8*NUM_BYTES-1:0] block_i;
  logic                   block_valid_i;
  logic                   block_ready_o;

  modport master (
    output block_i,
    output block_valid_i,
    input  block_ready_o
  );

  modport slave (
    input  block_i,
    input  block_valid_i,
    output block_ready_o
  );

endinterface

// File: rtl/aes_block_uart_tx.sv
// Serializes one AES block into bytes for a UART transmitter.
// Ports: clk, rst, blk (block handshake), tx_data_o/tx_start_o/
// tx_done_tick_i (UART TX side), busy_o, done_tick_o.
module aes_block_uart_tx
  import aes_uart_pkg::*;
#(
  parameter int NUM_BYTES  = AES_BLOCK_BYTES,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic                clk,
  input  logic                rst,
  aes_block_uart_tx_if.slave  blk,
  output logic [7:0]          tx_data_o,
  output logic                tx_start_o,
  input  logic                tx_done_tick_i,
  output logic                busy_o,
  output logic                done_tick_o
);

  localparam int W  = 8 * NUM_BYTES;
  localparam int CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int GW = 16;

  state_t          state;
  logic [W-1:0]    sreg;
  logic [W-1:0]    sreg_nxt;
  logic [CW-1:0]   cnt;
  logic [GW-1:0]   gcnt;
  logic            ready;

  // Head byte sits at the top for MSB-first, bottom otherwise.
  function automatic logic [7:0] head(input logic [W-1:0] v);
    if (MSB_FIRST != 0) return v[W-1 -: 8];
    else                return v[7:0];
  endfunction

  assign sreg_nxt = (MSB_FIRST != 0) ? (sreg << 8) : (sreg >> 8);

  assign blk.block_ready_o = ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      sreg        <= '0;
      cnt         <= '0;
      gcnt        <= '0;
      ready       <= 1'b1;
      busy_o      <= 1'b0;
      tx_start_o  <= 1'b0;
      tx_data_o   <= 8'h00;
      done_tick_o <= 1'b0;
    end else begin
      tx_start_o  <= 1'b0;
      done_tick_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (blk.block_valid_i && ready) begin
            sreg       <= blk.block_i;
            cnt        <= '0;
            ready      <= 1'b0;
            busy_o     <= 1'b1;
            tx_start_o <= 1'b1;
            tx_data_o  <= head(blk.block_i);
            state      <= S_START;
          end
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done_tick_i) begin
            if (cnt == CW'(NUM_BYTES - 1)) begin
              ready       <= 1'b1;
              busy_o      <= 1'b0;
              done_tick_o <= 1'b1;
              state       <= S_IDLE;
            end else begin
              sreg <= sreg_nxt;
              cnt  <= cnt + 1'b1;
              if (GAP_CYCLES > 0) begin
                gcnt  <= '0;
                state <= S_GAP;
              end else begin
                // Start is registered, so it lands the cycle after the tick.
                tx_start_o <= 1'b1;
                tx_data_o  <= head(sreg_nxt);
                state      <= S_START;
              end
            end
          end
        end
        S_GAP: begin
          if (gcnt == GW'(GAP_CYCLES - 1)) begin
            tx_start_o <= 1'b1;
            tx_data_o  <= head(sreg);
            state      <= S_START;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: begin
          ready  <= 1'b1;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_uart_tx.sv
// Self-checking bench for aes_block_uart_tx.
// Four instances: default, LSB-first, gap=5, single byte.
module tb_aes_block_uart_tx;
  import aes_uart_pkg::*;

  localparam int NI  = 4;
  localparam int LAT = 20;

  function automatic int gap_of(int i);
    return (i == 2) ? 5 : 0;
  endfunction
  function automatic int nb_of(int i);
    return (i == 3) ? 1 : 16;
  endfunction
  function automatic bit msb_of(int i);
    return (i != 1);
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0]        blkv [NI];
  logic [NI-1:0]       valid = '0;
  logic [NI-1:0]       ready;
  logic [NI-1:0][7:0]  data;
  logic [NI-1:0]       start;
  logic [NI-1:0]       dout;
  logic [NI-1:0]       busy;
  logic [NI-1:0]       tick;
  logic [NI-1:0]       tick_m = '0;
  logic [NI-1:0]       spur = '0;

  assign tick = tick_m | spur;

  aes_block_uart_tx_if #(.NUM_BYTES(16)) bif0 ();
  aes_block_uart_tx_if #(.NUM_BYTES(16)) bif1 ();
  aes_block_uart_tx_if #(.NUM_BYTES(16)) bif2 ();
  aes_block_uart_tx_if #(.NUM_BYTES(1))  bif3 ();

  assign bif0.block_i = blkv[0];
  assign bif1.block_i = blkv[1];
  assign bif2.block_i = blkv[2];
  assign bif3.block_i = blkv[3][7:0];
  assign bif0.block_valid_i = valid[0];
  assign bif1.block_valid_i = valid[1];
  assign bif2.block_valid_i = valid[2];
  assign bif3.block_valid_i = valid[3];
  assign ready[0] = bif0.block_ready_o;
  assign ready[1] = bif1.block_ready_o;
  assign ready[2] = bif2.block_ready_o;
  assign ready[3] = bif3.block_ready_o;

  aes_block_uart_tx #(.NUM_BYTES(16), .MSB_FIRST(1), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .blk(bif0.slave),
    .tx_data_o(data[0]), .tx_start_o(start[0]),
    .tx_done_tick_i(tick[0]), .busy_o(busy[0]),
    .done_tick_o(dout[0]));
  aes_block_uart_tx #(.NUM_BYTES(16), .MSB_FIRST(0), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .blk(bif1.slave),
    .tx_data_o(data[1]), .tx_start_o(start[1]),
    .tx_done_tick_i(tick[1]), .busy_o(busy[1]),
    .done_tick_o(dout[1]));
  aes_block_uart_tx #(.NUM_BYTES(16), .MSB_FIRST(1), .GAP_CYCLES(5)) u2 (
    .clk(clk), .rst(rst), .blk(bif2.slave),
    .tx_data_o(data[2]), .tx_start_o(start[2]),
    .tx_done_tick_i(tick[2]), .busy_o(busy[2]),
    .done_tick_o(dout[2]));
  aes_block_uart_tx #(.NUM_BYTES(1), .MSB_FIRST(1), .GAP_CYCLES(0)) u3 (
    .clk(clk), .rst(rst), .blk(bif3.slave),
    .tx_data_o(data[3]), .tx_start_o(start[3]),
    .tx_done_tick_i(tick[3]), .busy_o(busy[3]),
    .done_tick_o(dout[3]));

  int vecs = 0;
  int errs = 0;

  task automatic chk(string n, int i, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s inst%0d cyc%0d: got %0h want %0h",
               n, i, cyc, act, exp);
    end
  endtask

  // Reference model state, driven only by spec-level events.
  bit          m_busy [NI];
  bit          m_wait [NI];
  bit          m_first[NI];
  int          nstart [NI];
  int          ndone  [NI];
  int          sched  [NI];
  int          last_done[NI];
  int          done_cyc [NI];
  int          nstarts[NI];
  int          ndones [NI];
  logic [7:0]  cur    [NI];
  logic [7:0]  q      [NI][$];
  logic [7:0]  log_b  [NI][$];
  int          log_c  [NI][$];

  initial begin
    for (int i = 0; i < NI; i++) begin
      nstart[i] = -1; ndone[i] = -1; sched[i] = -1;
      last_done[i] = 0; done_cyc[i] = 0;
      nstarts[i] = 0; ndones[i] = 0;
      m_busy[i] = 0; m_wait[i] = 0; m_first[i] = 0;
      cur[i] = 8'h00; blkv[i] = '0;
    end
  end

  // UART TX stand-in: done tick LAT cycles after each start.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++)
      tick_m[i] <= !rst && (sched[i] == cyc + 1);
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        chk("rst_start", i, 32'(start[i]), 0);
        chk("rst_data",  i, 32'(data[i]), 0);
        chk("rst_done",  i, 32'(dout[i]), 0);
        chk("rst_ready", i, 32'(ready[i]), 1);
        chk("rst_busy",  i, 32'(busy[i]), 0);
        m_busy[i] = 0; m_wait[i] = 0;
        nstart[i] = -1; ndone[i] = -1; sched[i] = -1;
        q[i].delete();
      end else begin
        automatic bit es = m_busy[i] && (cyc == nstart[i]);
        chk("start", i, 32'(start[i]), 32'(es));
        chk("done",  i, 32'(dout[i]), 32'(cyc == ndone[i]));
        chk("ready", i, 32'(ready[i]), 32'(!m_busy[i]));
        chk("busy",  i, 32'(busy[i]), 32'(m_busy[i]));
        if (start[i]) begin
          nstarts[i]++;
          sched[i] = cyc + LAT;
          log_b[i].push_back(data[i]);
          log_c[i].push_back(cyc);
          if (i == 2 && !m_first[i])
            chk("gap_dist", i, 32'(cyc - last_done[i]), 6);
          m_first[i] = 0;
        end
        if (es) begin
          cur[i] = q[i].pop_front();
          m_wait[i] = 1;
        end
        if (m_wait[i]) chk("data", i, 32'(data[i]), 32'(cur[i]));
        if (dout[i]) begin
          ndones[i]++;
          done_cyc[i] = cyc;
        end
        if (!m_busy[i] && valid[i]) begin
          for (int k = 0; k < nb_of(i); k++)
            q[i].push_back(msb_of(i) ?
              blkv[i][8*(nb_of(i)-1-k) +: 8] : blkv[i][8*k +: 8]);
          m_busy[i] = 1;
          m_first[i] = 1;
          nstart[i] = cyc + 1;
        end else if (m_wait[i] && tick[i]) begin
          m_wait[i] = 0;
          last_done[i] = cyc;
          if (q[i].size() == 0) begin
            ndone[i] = cyc + 1;
            m_busy[i] = 0;
          end else begin
            nstart[i] = cyc + 1 + gap_of(i);
          end
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_dones(int i, int target, int bound);
    int n = 0;
    while (ndones[i] < target && n < bound) begin
      @(posedge clk);
      n++;
    end
    #1;
    vecs++;
    if (ndones[i] < target) begin
      errs++;
      $display("FAIL timeout_done inst%0d: got %0d want %0d",
               i, ndones[i], target);
    end
  endtask

  task automatic send(int i, logic [127:0] b);
    int n = 0;
    blkv[i] = b;
    valid[i] = 1'b1;
    @(negedge clk);
    while (!ready[i] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    valid[i] = 1'b0;
    vecs++;
    if (n >= 2000) begin
      errs++;
      $display("FAIL timeout_ready inst%0d: got 0 want 1", i);
    end
  endtask

  localparam logic [127:0] BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] BLK_B = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] BLK_C = 128'h0123456789ABCDEFFEDCBA9876543210;

  initial begin
    int base;
    int d;
    logic [7:0] e;
    step(3);
    rst = 1'b0;
    step(2);

    // Basic, LSB-first, gap and single-byte blocks in parallel.
    blkv[0] = BLK_A; blkv[1] = BLK_A; blkv[2] = BLK_A;
    blkv[3] = 128'hA5;
    valid = '1;
    step(1);
    valid = '0;
    for (int i = 0; i < NI; i++) wait_dones(i, 1, 1000);
    step(3);
    for (int i = 0; i < NI; i++) begin
      chk("done_count", i, 32'(ndones[i]), 1);
      chk("start_count", i, 32'(nstarts[i]), 32'(nb_of(i)));
      chk("done_lat", i, 32'(done_cyc[i] - last_done[i]), 1);
    end
    for (int k = 0; k < 16; k++) begin
      e = 8'(8'h11 * k);
      chk("msb_byte", 0, 32'(log_b[0][k]), 32'(e));
      chk("lsb_byte", 1, 32'(log_b[1][k]), 32'(8'hFF - e));
    end
    chk("single_byte", 3, 32'(log_b[3][0]), 32'hA5);

    // Second block held valid while busy; spurious tick when idle.
    base = log_c[0].size();
    send(0, BLK_A);
    blkv[0] = BLK_B;
    valid[0] = 1'b1;
    wait_dones(0, 2, 1000);
    d = done_cyc[0];
    step(1);
    valid[0] = 1'b0;
    wait_dones(0, 3, 1000);
    chk("second_start", 0, 32'(log_c[0][base+16] - d), 1);
    chk("second_first", 0, 32'(log_b[0][base+16]), 32'h0F);
    step(2);
    spur[0] = 1'b1;
    step(1);
    spur[0] = 1'b0;
    step(4);
    chk("spur_starts", 0, 32'(nstarts[0]), 48);

    // Asynchronous reset after the third start of a block.
    base = nstarts[0];
    send(0, BLK_C);
    begin
      int n = 0;
      while (nstarts[0] < base + 3 && n < 200) begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    #1;
    rst = 1'b1;
    #1;
    chk("arst_start", 0, 32'(start[0]), 0);
    chk("arst_data",  0, 32'(data[0]), 0);
    chk("arst_busy",  0, 32'(busy[0]), 0);
    chk("arst_ready", 0, 32'(ready[0]), 1);
    chk("arst_done",  0, 32'(dout[0]), 0);
    step(2);
    rst = 1'b0;
    step(80);
    chk("arst_nostart", 0, 32'(nstarts[0]), 32'(base + 3));
    chk("arst_ready_after", 0, 32'(ready[0]), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
